// File: rtl/dht22_frame_decoder_if.sv
// Bus between the DHT22 frame decoder (slave) and its frame source / CPU-side consumer (master).
// Also carries the decoder's debug state so checkers can bind to one place.
interface dht22_frame_decoder_if;
    logic [39:0] frame_in;
    logic        frame_stb;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] humidity;
    logic [15:0] temp;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;
    logic [15:0] frame_cnt;
    logic        stale;
    logic        minmax_clr;
    logic [15:0] t_min;
    logic [15:0] t_max;
    logic [1:0]  dbg_state;

    modport master (
        output frame_in, frame_stb, out_ready, minmax_clr,
        input  out_valid, humidity, temp, err_cnt, drop_cnt, frame_cnt,
               stale, t_min, t_max, dbg_state
    );

    modport slave (
        input  frame_in, frame_stb, out_ready, minmax_clr,
        output out_valid, humidity, temp, err_cnt, drop_cnt, frame_cnt,
               stale, t_min, t_max, dbg_state
    );
endinterface

// File: rtl/dht22_frame_decoder.sv
// Validates raw DHT22 frames, converts temperature to two's complement and hands readings out.
// Optional min/max temperature tracker enabled by defining DHT_MINMAX_EN.
module dht22_frame_decoder #(
    parameter int unsigned STALE_CYCLES = 100_000_000,
    parameter int unsigned HUM_MAX      = 1000,
    parameter int unsigned TEMP_MAG_MAX = 800
) (
    input  logic                        clk,
    input  logic                        rst,
    dht22_frame_decoder_if.slave        bus
);
    localparam int unsigned STALE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CONVERT, S_HOLD} state_t;

    state_t             r_state;
    logic [39:0]        r_frame;
    logic               r_out_valid;
    logic [15:0]        r_humidity;
    logic [15:0]        r_temp;
    logic [7:0]         r_err_cnt;
    logic [7:0]         r_drop_cnt;
    logic [15:0]        r_frame_cnt;
    logic [STALE_W-1:0] r_stale_cnt;
    logic               r_stale;

    logic [9:0]  w_sum;
    logic        w_cks_ok;
    logic [15:0] w_hum;
    logic [15:0] w_mag;
    logic [15:0] w_temp;
    logic        w_range_ok;
    logic        w_hold_entry;

    assign w_sum = {2'b00, r_frame[39:32]} + {2'b00, r_frame[31:24]}
                 + {2'b00, r_frame[23:16]} + {2'b00, r_frame[15:8]};
    assign w_cks_ok     = (w_sum[7:0] == r_frame[7:0]);
    assign w_hum        = r_frame[39:24];
    assign w_mag        = {1'b0, r_frame[22:8]};
    assign w_temp       = r_frame[23] ? (16'd0 - w_mag) : w_mag;
    assign w_range_ok   = (w_hum <= 16'(HUM_MAX)) && (w_mag <= 16'(TEMP_MAG_MAX));
    assign w_hold_entry = (r_state == S_CONVERT) && w_range_ok;

    // Handshake: a reading transfers on a rising clk edge where out_valid && out_ready;
    // out_valid stays high and humidity/temp stay stable until that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_out_valid <= 1'b0;
            r_humidity  <= '0;
            r_temp      <= '0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_frame_cnt <= '0;
            r_stale_cnt <= '0;
            r_stale     <= 1'b1;
        end else begin
            if (bus.frame_stb && (r_state != S_IDLE) && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;

            // stale stays set from reset until the first good frame, then tracks the counter
            if (w_hold_entry) begin
                r_stale_cnt <= '0;
                r_stale     <= 1'b0;
            end else if (r_stale_cnt < STALE_MAX) begin
                r_stale_cnt <= r_stale_cnt + 1'b1;
                if (r_stale_cnt + 1'b1 == STALE_MAX)
                    r_stale <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.frame_stb) begin
                        r_frame <= bus.frame_in;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_cks_ok) begin
                        r_state <= S_CONVERT;
                    end else begin
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        r_state <= S_IDLE;
                    end
                end
                S_CONVERT: begin
                    if (w_range_ok) begin
                        r_humidity  <= w_hum;
                        r_temp      <= w_temp;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.humidity  = r_humidity;
    assign bus.temp      = r_temp;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.drop_cnt  = r_drop_cnt;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.stale     = r_stale;
    assign bus.dbg_state = r_state;

`ifdef DHT_MINMAX_EN
    logic signed [15:0] r_t_min;
    logic signed [15:0] r_t_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t_min <= 16'sh7FFF;
            r_t_max <= 16'sh8000;
        end else if (bus.minmax_clr) begin
            r_t_min <= 16'sh7FFF;
            r_t_max <= 16'sh8000;
        end else if (w_hold_entry) begin
            if ($signed(w_temp) < r_t_min) r_t_min <= $signed(w_temp);
            if ($signed(w_temp) > r_t_max) r_t_max <= $signed(w_temp);
        end
    end

    assign bus.t_min = r_t_min;
    assign bus.t_max = r_t_max;
`else
    logic w_unused_minmax_clr;
    assign w_unused_minmax_clr = bus.minmax_clr;
    assign bus.t_min = '0;
    assign bus.t_max = '0;
`endif
endmodule

// File: tb/tb_dht22_frame_decoder.sv
// Self-checking bench for dht22_frame_decoder with a short staleness window.
// Checks the min/max tracker when DHT_MINMAX_EN is defined, otherwise its constant-zero outputs.
module tb_dht22_frame_decoder;
    localparam int STALE = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dht22_frame_decoder_if bus();

    dht22_frame_decoder #(.STALE_CYCLES(STALE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_err, m_drop, m_frames;
    logic [31:0] exp_q[$];

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Reference: {accept, humidity, temp} computed from the frame's arithmetic meaning
    function automatic logic [32:0] model_decode(input logic [39:0] f);
        int sum, hum, mag, t;
        logic [15:0] t16;
        logic ok;
        sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
        hum = int'(f[39:24]);
        mag = int'(f[22:8]);
        t   = f[23] ? -mag : mag;
        t16 = t[15:0];
        ok  = (sum == int'(f[7:0])) && (hum <= 1000) && (mag <= 800);
        return {ok, f[39:24], t16};
    endfunction

    function automatic logic [39:0] make_frame(input int hum, input bit neg, input int mag, input bit bad_cks);
        logic [15:0] h, tw;
        logic [7:0] c;
        int s;
        h  = 16'(hum);
        tw = {neg, 15'(mag)};
        s  = int'(h[15:8]) + int'(h[7:0]) + int'(tw[15:8]) + int'(tw[7:0]);
        c  = 8'(s % 256);
        if (bad_cks) c = c + 8'($urandom_range(1, 255));
        return {h, tw, c};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_err = 0; m_drop = 0; m_frames = 0;
    endtask

    // Drives one frame and follows it to delivery or rejection
    task automatic run_frame(input logic [39:0] f, input string tag);
        logic [32:0] m;
        int lat;
        bit seen;
        m = model_decode(f);
        @(negedge clk); bus.frame_in = f; bus.frame_stb = 1'b1;
        @(negedge clk); bus.frame_stb = 1'b0; lat = 1;
        if (m[32]) begin
            while (bus.out_valid !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
            n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL %s latency: got %0d expected 3", tag, lat); end
            n_checks++; if (bus.humidity !== m[31:16]) begin n_errors++; $display("FAIL %s humidity: got %0d expected %0d", tag, bus.humidity, m[31:16]); end
            n_checks++; if (bus.temp !== m[15:0]) begin n_errors++; $display("FAIL %s temp: got %h expected %h", tag, bus.temp, m[15:0]); end
            n_checks++; if (bus.stale !== 1'b0) begin n_errors++; $display("FAIL %s stale: got %b expected 0", tag, bus.stale); end
            bus.out_ready = 1'b1;
            @(negedge clk); bus.out_ready = 1'b0;
            m_frames++;
            n_checks++; if (bus.frame_cnt !== 16'(m_frames)) begin n_errors++; $display("FAIL %s frame_cnt: got %0d expected %0d", tag, bus.frame_cnt, m_frames); end
            n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL %s valid_after_hs: got %b expected 0", tag, bus.out_valid); end
        end else begin
            seen = 1'b0;
            repeat (4) begin if (bus.out_valid === 1'b1) seen = 1'b1; @(negedge clk); end
            m_err = sat_inc(m_err);
            n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL %s rejected_valid: got 1 expected 0", tag); end
            n_checks++; if (bus.err_cnt !== 8'(m_err)) begin n_errors++; $display("FAIL %s err_cnt: got %0d expected %0d", tag, bus.err_cnt, m_err); end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.humidity !== 16'd0 || bus.temp !== 16'd0) begin n_errors++; $display("FAIL reset data: got %h/%h expected 0/0", bus.humidity, bus.temp); end
        n_checks++; if (bus.err_cnt !== 8'd0 || bus.drop_cnt !== 8'd0 || bus.frame_cnt !== 16'd0) begin n_errors++; $display("FAIL reset counters: got %0d/%0d/%0d expected 0/0/0", bus.err_cnt, bus.drop_cnt, bus.frame_cnt); end
        n_checks++; if (bus.stale !== 1'b1) begin n_errors++; $display("FAIL reset stale: got %b expected 1", bus.stale); end
        n_checks++; if (bus.dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset state: got %0d expected 0", bus.dbg_state); end
        rst = 1'b0;
        m_err = 0; m_drop = 0; m_frames = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.stale !== 1'b1 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset idle: got stale=%b valid=%b expected 1/0", bus.stale, bus.out_valid); end
    endtask

    task automatic test_good_frame();
        run_frame(40'h028C_015F_EE, "good_frame");
    endtask

    task automatic test_negative();
        run_frame(40'h028C_8065_73, "neg_temp");
        run_frame(40'h0000_8000_80, "neg_zero");
        run_frame(make_frame(0, 1'b1, 800, 1'b0), "mag_800");
        run_frame(make_frame(1000, 1'b0, 0, 1'b0), "hum_1000");
    endtask

    task automatic test_errors();
        run_frame(40'h028C_015F_EF, "bad_cks");
        run_frame(40'h03E9_0000_EC, "hum_1001");
        run_frame(make_frame(0, 1'b1, 801, 1'b0), "mag_801");
    endtask

    task automatic test_drop();
        logic [39:0] fa, fb;
        int w;
        fa = 40'h028C_015F_EE;
        fb = make_frame(123, 1'b0, 45, 1'b0);
        bus.out_ready = 1'b0;
        @(negedge clk); bus.frame_in = fa; bus.frame_stb = 1'b1;
        @(negedge clk); bus.frame_in = fb;
        @(negedge clk); bus.frame_stb = 1'b0; m_drop = sat_inc(m_drop);
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 8) begin @(negedge clk); w++; end
        n_checks++; if (bus.humidity !== 16'd652 || bus.temp !== 16'd351) begin n_errors++; $display("FAIL drop_check_stb data: got %0d/%0d expected 652/351", bus.humidity, bus.temp); end
        bus.frame_stb = 1'b1;
        @(negedge clk); bus.frame_stb = 1'b0; m_drop = sat_inc(m_drop);
        n_checks++; if (bus.drop_cnt !== 8'(m_drop)) begin n_errors++; $display("FAIL drop_hold cnt: got %0d expected %0d", bus.drop_cnt, m_drop); end
        n_checks++; if (bus.out_valid !== 1'b1 || bus.humidity !== 16'd652 || bus.temp !== 16'd351) begin n_errors++; $display("FAIL drop_hold held: got v=%b %0d/%0d expected 1 652/351", bus.out_valid, bus.humidity, bus.temp); end
        bus.out_ready = 1'b1; bus.frame_stb = 1'b1;
        @(negedge clk); bus.out_ready = 1'b0; bus.frame_stb = 1'b0;
        m_drop = sat_inc(m_drop); m_frames++;
        n_checks++; if (bus.drop_cnt !== 8'(m_drop) || bus.frame_cnt !== 16'(m_frames)) begin n_errors++; $display("FAIL drop_handshake cnts: got %0d/%0d expected %0d/%0d", bus.drop_cnt, bus.frame_cnt, m_drop, m_frames); end
        w = 0;
        repeat (5) begin if (bus.out_valid === 1'b1) w++; @(negedge clk); end
        n_checks++; if (w !== 0) begin n_errors++; $display("FAIL drop_handshake captured: got %0d valid cycles expected 0", w); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] f;
        logic [32:0] m;
        logic [31:0] e;
        int got;
        got = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f = make_frame($urandom_range(0, 1000), 1'($urandom_range(0, 1)), $urandom_range(0, 800), 1'b0);
            m = model_decode(f);
            @(negedge clk); bus.frame_in = f; bus.frame_stb = 1'b1;
            exp_q.push_back(m[31:0]);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); bus.frame_stb = 1'b0;
                if (bus.out_valid === 1'b1) begin
                    got++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++; $display("FAIL b2b unexpected: got %h/%h expected none", bus.humidity, bus.temp);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.humidity, bus.temp} !== e) begin n_errors++; $display("FAIL b2b reading: got %h expected %h", {bus.humidity, bus.temp}, e); end
                    end
                end
            end
        end
        @(negedge clk); bus.out_ready = 1'b0;
        m_frames += 8;
        n_checks++; if (got !== 8 || exp_q.size() !== 0) begin n_errors++; $display("FAIL b2b count: got %0d left %0d expected 8 left 0", got, exp_q.size()); end
        n_checks++; if (bus.frame_cnt !== 16'(m_frames) || bus.drop_cnt !== 8'(m_drop)) begin n_errors++; $display("FAIL b2b cnts: got %0d/%0d expected %0d/%0d", bus.frame_cnt, bus.drop_cnt, m_frames, m_drop); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_frame(make_frame($urandom_range(0, 1100), 1'($urandom_range(0, 1)), $urandom_range(0, 900),
                                 $urandom_range(0, 3) == 0), "random");
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); bus.frame_in = make_frame($urandom_range(0, 1000), 1'b0, $urandom_range(0, 800), 1'b1);
            bus.frame_stb = 1'b1;
            @(negedge clk); bus.frame_stb = 1'b0;
            @(negedge clk);
            m_err = sat_inc(m_err);
        end
        n_checks++; if (bus.err_cnt !== 8'(m_err)) begin n_errors++; $display("FAIL err_sat: got %0d expected %0d", bus.err_cnt, m_err); end
        n_checks++; if (bus.drop_cnt !== 8'(m_drop)) begin n_errors++; $display("FAIL err_sat drop: got %0d expected %0d", bus.drop_cnt, m_drop); end
    endtask

    task automatic test_stale();
        int k;
        @(negedge clk); bus.frame_in = 40'h028C_015F_EE; bus.frame_stb = 1'b1;
        @(negedge clk); bus.frame_stb = 1'b0;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 8) begin @(negedge clk); k++; end
        n_checks++; if (bus.stale !== 1'b0) begin n_errors++; $display("FAIL stale_entry: got %b expected 0", bus.stale); end
        bus.out_ready = 1'b1;
        k = 0;
        while (bus.stale !== 1'b1 && k < 20) begin @(negedge clk); k++; bus.out_ready = 1'b0; end
        m_frames++;
        n_checks++; if (k !== STALE) begin n_errors++; $display("FAIL stale_rise: got %0d cycles expected %0d", k, STALE); end
        run_frame(make_frame(400, 1'b0, 250, 1'b0), "stale_clear");
        @(negedge clk); bus.frame_in = 40'h028C_015F_EE; bus.frame_stb = 1'b1;
        @(negedge clk); bus.frame_stb = 1'b0;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 8) begin @(negedge clk); k++; end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.dbg_state !== 2'd0) begin n_errors++; $display("FAIL rst_in_hold: got v=%b st=%0d expected 0/0", bus.out_valid, bus.dbg_state); end
        @(negedge clk); rst = 1'b0;
        m_err = 0; m_drop = 0; m_frames = 0;
        @(negedge clk);
        n_checks++; if (bus.stale !== 1'b1 || bus.frame_cnt !== 16'd0 || bus.err_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_in_hold regs: got %b/%0d/%0d expected 1/0/0", bus.stale, bus.frame_cnt, bus.err_cnt); end
    endtask

    task automatic test_minmax();
        int temps[3] = '{351, -101, 200};
        int tmin, tmax;
        do_reset();
        tmin = 32767; tmax = -32768;
        for (int i = 0; i < 3; i++) begin
            run_frame(make_frame(652, temps[i] < 0, (temps[i] < 0) ? -temps[i] : temps[i], 1'b0), "minmax");
            if (temps[i] < tmin) tmin = temps[i];
            if (temps[i] > tmax) tmax = temps[i];
        end
`ifdef DHT_MINMAX_EN
        n_checks++; if (bus.t_min !== 16'(tmin) || bus.t_max !== 16'(tmax)) begin n_errors++; $display("FAIL minmax track: got %h/%h expected %h/%h", bus.t_min, bus.t_max, 16'(tmin), 16'(tmax)); end
`else
        n_checks++; if (bus.t_min !== 16'd0 || bus.t_max !== 16'd0) begin n_errors++; $display("FAIL minmax off: got %h/%h expected 0/0", bus.t_min, bus.t_max); end
`endif
        @(negedge clk); bus.minmax_clr = 1'b1;
        @(negedge clk); bus.minmax_clr = 1'b0;
`ifdef DHT_MINMAX_EN
        n_checks++; if (bus.t_min !== 16'h7FFF || bus.t_max !== 16'h8000) begin n_errors++; $display("FAIL minmax clr: got %h/%h expected 7fff/8000", bus.t_min, bus.t_max); end
`else
        n_checks++; if (bus.t_min !== 16'd0 || bus.t_max !== 16'd0) begin n_errors++; $display("FAIL minmax clr_off: got %h/%h expected 0/0", bus.t_min, bus.t_max); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_in = '0; bus.frame_stb = 1'b0; bus.out_ready = 1'b0; bus.minmax_clr = 1'b0;
        test_reset();
        test_good_frame();
        test_negative();
        test_errors();
        test_drop();
        test_back_to_back();
        test_random();
        test_err_saturation();
        test_stale();
        test_minmax();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
